// File: rtl/hdlc_tx_sched_if.sv
// Handshake/bus bundle between the HDLC transmit scheduler and its frame source.
// The master drives frame requests and buffer data; the slave (scheduler) drives the serial line.
interface hdlc_tx_sched_if;
    logic       Tx_Enable;
    logic [7:0] Tx_FrameSize;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_Data;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;
    logic       Tx_Done;

    modport master (
        output Tx_Enable, Tx_FrameSize, Tx_AbortFrame, Tx_Data,
        input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
    );

    modport slave (
        input  Tx_Enable, Tx_FrameSize, Tx_AbortFrame, Tx_Data,
        output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
    );
endinterface

// File: rtl/hdlc_tx_sched.sv
// HDLC transmit scheduler: start flag, LSB-first bit-stuffed data, end flag, one bit per clock.
// Define HDLC_TX_ABORT_EN to build the ABORT state; otherwise Tx_AbortFrame is ignored.
module hdlc_tx_sched (
    input  logic           Clk,
    input  logic           Rst,
    hdlc_tx_sched_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_FLAG = 3'd1,
        DATA       = 3'd2,
        END_FLAG   = 3'd3
`ifdef HDLC_TX_ABORT_EN
        ,
        ABORT      = 3'd4
`endif
    } state_t;

    function automatic logic flag_bit(input logic [2:0] idx);
        return (idx != 3'd0) && (idx != 3'd7);
    endfunction

`ifdef HDLC_TX_ABORT_EN
    function automatic logic abort_bit(input logic [2:0] idx);
        return idx != 3'd0;
    endfunction
`endif

    state_t     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] ones_q, ones_d;
    logic       stuff_q, stuff_d;
    logic [7:0] byte_q, byte_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] size_q, size_d;
    logic       tx_q, tx_d;
    logic       rd_q, rd_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
`ifdef HDLC_TX_ABORT_EN
    logic       abrt_q, abrt_d;
`endif

    logic [2:0] nxt_idx_s;
    logic [7:0] next_byte_s;
    logic       last_s;
    logic       size_ok_s;

    // The buffer answers a pop with data that is sampled on the edge closing the pop cycle.
    assign nxt_idx_s   = bit_q + 3'd1;
    assign next_byte_s = rd_q ? bus.Tx_Data : byte_q;
    assign last_s      = (cnt_q == size_q);
    assign size_ok_s   = (bus.Tx_FrameSize != 8'd0) && (bus.Tx_FrameSize <= 8'd126);

    // Next-state and next-output logic; registers describe the bit currently on Tx.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        ones_d  = ones_q;
        stuff_d = 1'b0;
        byte_d  = next_byte_s;
        cnt_d   = cnt_q;
        size_d  = size_q;
        tx_d    = 1'b1;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        valid_d = 1'b0;
`ifdef HDLC_TX_ABORT_EN
        abrt_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Tx_Enable && size_ok_s) begin
                    state_d = START_FLAG;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    size_d  = bus.Tx_FrameSize[6:0];
                    cnt_d   = 7'd0;
                    ones_d  = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START_FLAG: begin
                if (bit_q == 3'd7) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    cnt_d   = 7'd1;
                    tx_d    = next_byte_s[0];
                    ones_d  = {2'b00, next_byte_s[0]};
                end else begin
                    bit_d = nxt_idx_s;
                    tx_d  = flag_bit(nxt_idx_s);
                    rd_d  = (nxt_idx_s == 3'd7);
                end
            end
            DATA: begin
                // A stuffed zero holds the bit index; the ones run restarts after it.
                if (!stuff_q && (ones_q == 3'd5)) begin
                    stuff_d = 1'b1;
                    tx_d    = 1'b0;
                    ones_d  = 3'd0;
                end else if (bit_q == 3'd7) begin
                    if (last_s) begin
                        state_d = END_FLAG;
                        bit_d   = 3'd0;
                        tx_d    = 1'b0;
                        ones_d  = 3'd0;
                    end else begin
                        bit_d  = 3'd0;
                        cnt_d  = cnt_q + 7'd1;
                        tx_d   = next_byte_s[0];
                        ones_d = next_byte_s[0] ? (ones_q + 3'd1) : 3'd0;
                    end
                end else begin
                    bit_d  = nxt_idx_s;
                    tx_d   = byte_q[nxt_idx_s];
                    ones_d = byte_q[nxt_idx_s] ? (ones_q + 3'd1) : 3'd0;
                    rd_d   = (nxt_idx_s == 3'd7) && !last_s;
                end
            end
            END_FLAG: begin
                if (bit_q == 3'd7) begin
                    state_d = IDLE;
                    bit_d   = 3'd0;
                    done_d  = 1'b1;
                end else begin
                    bit_d = nxt_idx_s;
                    tx_d  = flag_bit(nxt_idx_s);
                end
            end
`ifdef HDLC_TX_ABORT_EN
            ABORT: begin
                if (bit_q == 3'd7) begin
                    state_d = IDLE;
                    bit_d   = 3'd0;
                    abrt_d  = 1'b1;
                end else begin
                    bit_d = nxt_idx_s;
                    tx_d  = abort_bit(nxt_idx_s);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                bit_d   = 3'd0;
            end
        endcase
`ifdef HDLC_TX_ABORT_EN
        if (bus.Tx_AbortFrame && ((state_q == START_FLAG) || (state_q == DATA))) begin
            state_d = ABORT;
            bit_d   = 3'd0;
            tx_d    = 1'b0;
            rd_d    = 1'b0;
            stuff_d = 1'b0;
            ones_d  = 3'd0;
            valid_d = 1'b0;
        end else begin
            valid_d = (state_d == START_FLAG) || (state_d == DATA) || (state_d == END_FLAG);
        end
`else
        valid_d = (state_d == START_FLAG) || (state_d == DATA) || (state_d == END_FLAG);
`endif
    end

    // State and registered-output update with asynchronous reset to the idle line.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            bit_q   <= 3'd0;
            ones_q  <= 3'd0;
            stuff_q <= 1'b0;
            byte_q  <= 8'd0;
            cnt_q   <= 7'd0;
            size_q  <= 7'd0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef HDLC_TX_ABORT_EN
            abrt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            ones_q  <= ones_d;
            stuff_q <= stuff_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef HDLC_TX_ABORT_EN
            abrt_q  <= abrt_d;
`endif
        end
    end

    assign bus.Tx            = tx_q;
    assign bus.Tx_RdBuff     = rd_q;
    assign bus.Tx_ValidFrame = valid_q;
    assign bus.Tx_Done       = done_q;
`ifdef HDLC_TX_ABORT_EN
    assign bus.Tx_AbortedTrans = abrt_q;
`else
    assign bus.Tx_AbortedTrans = 1'b0;
`endif
endmodule
